// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex driver for an N-digit common-anode
// 7-segment display. A load captures a packed hex word into a staging
// register. The staging register is copied to the display register only at
// the start of a frame, so an update never tears. One digit is lit at a time
// for CLK_DIV cycles, with BLANK_CYC dark cycles between digits.
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high
//   data_i   packed hex digits, digit k = data_i[4k+3:4k]
//   dp_i     decimal point request per digit (1 = lit)
//   blank_i  force digit dark (1 = dark)
//   load_i   capture data_i/dp_i/blank_i into staging
//   seg_o    segments {g,f,e,d,c,b,a}, active-low
//   dp_o     decimal point, active-low
//   an_o     digit enables, active-low, at most one low
//   frame_o  one-cycle pulse when digit 0 enters SHOW
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*N_DIGITS-1:0]   data_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_o
);

  localparam int unsigned DW      = 4 * N_DIGITS;
  localparam int unsigned CNT_MAX = ((CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DW-1:0]        stg_data_q, disp_data_q, disp_data_d;
  logic [N_DIGITS-1:0]  stg_dp_q, disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]  stg_blank_q, disp_blank_q, disp_blank_d;
  logic [6:0]           seg_q;
  logic                 dp_q;
  logic [N_DIGITS-1:0]  an_q;
  logic                 frame_q;

  logic                 blank_done_c, show_done_c, copy_c;
  logic [N_DIGITS-1:0]  lzb_c;
  logic [3:0]           digit_c;
  logic                 dark_c;
  logic [6:0]           seg_show_c;
  logic                 dp_show_c;

  // Active-low glyph set, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b100_0000;
      4'h1: glyph = 7'b111_1001;
      4'h2: glyph = 7'b010_0100;
      4'h3: glyph = 7'b011_0000;
      4'h4: glyph = 7'b001_1001;
      4'h5: glyph = 7'b001_0010;
      4'h6: glyph = 7'b000_0010;
      4'h7: glyph = 7'b111_1000;
      4'h8: glyph = 7'b000_0000;
      4'h9: glyph = 7'b001_0000;
      4'hA: glyph = 7'b000_1000;
      4'hB: glyph = 7'b000_0011;
      4'hC: glyph = 7'b100_0110;
      4'hD: glyph = 7'b010_0001;
      4'hE: glyph = 7'b000_0110;
      default: glyph = 7'b000_1110;
    endcase
  endfunction

  // Frame-boundary copy and the segment pattern for the digit about to light.
  // The pattern is taken from the post-copy display value so a load landing
  // on the copy edge is visible in the same SHOW window.
  always_comb begin
    blank_done_c = (state_q == ST_BLANK) && (cnt_q == CNT_W'(BLANK_CYC - 1));
    show_done_c  = (state_q == ST_SHOW)  && (cnt_q == CNT_W'(CLK_DIV - 1));
    copy_c       = blank_done_c && (idx_q == '0);

    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (copy_c) begin
      disp_data_d  = load_i ? data_i  : stg_data_q;
      disp_dp_d    = load_i ? dp_i    : stg_dp_q;
      disp_blank_d = load_i ? blank_i : stg_blank_q;
    end

    lzb_c = '0;
`ifdef SEG7_LZB_EN
    // Suppress zeros from the top down until a nonzero digit or a lit dp;
    // digit 0 is never suppressed.
    begin
      logic run;
      run = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
        run      = run && (disp_data_d[4*k +: 4] == 4'h0) && !disp_dp_d[k];
        lzb_c[k] = run;
      end
    end
`endif

    digit_c    = disp_data_d[4*int'(idx_q) +: 4];
    dark_c     = disp_blank_d[idx_q] | lzb_c[idx_q];
    seg_show_c = dark_c ? 7'h7F : glyph(digit_c);
    dp_show_c  = dark_c ? 1'b1 : ~disp_dp_d[idx_q];
  end

  // Scan FSM with staging/display registers and registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      if (load_i) begin
        stg_data_q  <= data_i;
        stg_dp_q    <= dp_i;
        stg_blank_q <= blank_i;
      end
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      frame_q      <= copy_c;

      case (state_q)
        ST_BLANK: begin
          if (blank_done_c) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            an_q    <= ~(N_DIGITS'(1) << idx_q);
            seg_q   <= seg_show_c;
            dp_q    <= dp_show_c;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_done_c) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, CLK_DIV=4, BLANK_CYC=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned BC = 2;

  // Hand-written active-low glyphs.
  localparam logic [6:0] G0 = 7'b100_0000;
  localparam logic [6:0] G1 = 7'b111_1001;
  localparam logic [6:0] G2 = 7'b010_0100;
  localparam logic [6:0] G3 = 7'b011_0000;
  localparam logic [6:0] G4 = 7'b001_1001;
  localparam logic [6:0] G5 = 7'b001_0010;
  localparam logic [6:0] G6 = 7'b000_0010;
  localparam logic [6:0] G7 = 7'b111_1000;
  localparam logic [6:0] G8 = 7'b000_0000;
  localparam logic [6:0] GA = 7'b000_1000;
  localparam logic [6:0] GF = 7'b000_1110;
  localparam logic [6:0] GX = 7'h7F;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [15:0]    data_i;
  logic [3:0]     dp_i;
  logic [3:0]     blank_i;
  logic           load_i;
  logic [6:0]     seg_o;
  logic           dp_o;
  logic [3:0]     an_o;
  logic           frame_o;

  int errors = 0;
  int checks = 0;

  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC)) u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .blank_i (blank_i),
    .load_i  (load_i),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .an_o    (an_o),
    .frame_o (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_i = d; dp_i = dp; blank_i = bl; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  // Advance until frame_o is seen, bounded.
  task automatic wait_frame();
    int n;
    n = 0;
    while (!frame_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!frame_o) check("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first SHOW cycle of digit k; checks the window and the
  // following dead time, and leaves the bench on the next digit's first SHOW
  // cycle. ld_show loads during the SHOW window; ld_end loads on the last
  // dead cycle so the load coincides with the next SHOW entry.
  task automatic check_digit(input int k, input logic [6:0] seg, input logic dpn,
                             input logic ld_show, input logic ld_end,
                             input logic [15:0] nd);
    logic [3:0] an_exp;
    an_exp = 4'hF;
    an_exp[k] = 1'b0;
    check($sformatf("an_d%0d", k), 32'(an_o), 32'(an_exp));
    check($sformatf("seg_d%0d", k), 32'(seg_o), 32'(seg));
    check($sformatf("dp_d%0d", k), 32'(dp_o), 32'(dpn));
    if (ld_show) begin
      data_i = nd; dp_i = 4'h0; blank_i = 4'h0; load_i = 1'b1;
    end
    @(negedge clk_i);
    load_i = 1'b0;
    tick(CD - 2);
    check($sformatf("an_hold_d%0d", k), 32'(an_o), 32'(an_exp));
    check($sformatf("seg_hold_d%0d", k), 32'(seg_o), 32'(seg));
    tick(1);
    check($sformatf("an_dead_d%0d", k), 32'(an_o), 32'hF);
    check($sformatf("seg_dead_d%0d", k), 32'(seg_o), 32'(GX));
    tick(BC - 1);
    if (ld_end) begin
      data_i = nd; dp_i = 4'h0; blank_i = 4'h0; load_i = 1'b1;
    end
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpn);
    check("frame_pulse", 32'(frame_o), 32'd1);
    check_digit(0, s0, dpn[0], 1'b0, 1'b0, 16'h0);
    check_digit(1, s1, dpn[1], 1'b0, 1'b0, 16'h0);
    check_digit(2, s2, dpn[2], 1'b0, 1'b0, 16'h0);
    check_digit(3, s3, dpn[3], 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1; data_i = '0; dp_i = '0; blank_i = '0; load_i = 1'b0;

    // Reset held for 3 cycles.
    tick(3);
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'(GX));
    check("rst_dp", 32'(dp_o), 32'd1);
    check("rst_frame", 32'(frame_o), 32'd0);
    rst_i = 1'b0;
    tick(1);
    check("post_rst_c1_an", 32'(an_o), 32'hF);
    tick(1);
    check("post_rst_c2_an", 32'(an_o), 32'hE);
    check("post_rst_frame", 32'(frame_o), 32'd1);
    check("post_rst_seg", 32'(seg_o), 32'(G0));
    tick(3);
    check("post_rst_c5_an", 32'(an_o), 32'hE);
    tick(1);
    check("post_rst_c6_an", 32'(an_o), 32'hF);
    // Frame period measured from here to the next pulse (4 cycles in).
    n = 4;
    while (!frame_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("frame_period", 32'(n), 32'd24);

    // Basic pattern with a decimal point on digit 2.
    do_load(16'hA1F0, 4'b0100, 4'b0000);
    wait_frame();
    check_frame(G0, GF, G1, GA, 4'b1011);

    // Mid-frame load: current frame keeps the old value.
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_frame();
    check_frame(G4, G3, G2, G1, 4'b1111);
    check_digit(0, G4, 1'b1, 1'b0, 1'b0, 16'h0);
    check_digit(1, G3, 1'b1, 1'b0, 1'b0, 16'h0);
    check_digit(2, G2, 1'b1, 1'b1, 1'b0, 16'h5678);
    check_digit(3, G1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_frame(G8, G7, G6, G5, 4'b1111);

    // Load on the digit-0 copy edge is visible immediately.
    check_digit(0, G8, 1'b1, 1'b0, 1'b0, 16'h0);
    check_digit(1, G7, 1'b1, 1'b0, 1'b0, 16'h0);
    check_digit(2, G6, 1'b1, 1'b0, 1'b0, 16'h0);
    check_digit(3, G5, 1'b1, 1'b0, 1'b1, 16'h4321);
    check_frame(G1, G2, G3, G4, 4'b1111);

    // Forced blanking of digit 3; its enable still goes low.
    do_load(16'h8888, 4'b1000, 4'b1000);
    wait_frame();
    check_frame(G8, G8, G8, GX, 4'b1111);

`ifdef SEG7_LZB_EN
    do_load(16'h0030, 4'b0000, 4'b0000);
    wait_frame();
    check_frame(G0, G3, GX, GX, 4'b1111);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    check_frame(G0, GX, GX, GX, 4'b1111);
    do_load(16'h0000, 4'b0100, 4'b0000);
    wait_frame();
    check_frame(G0, G0, G0, GX, 4'b1011);
`else
    do_load(16'h0030, 4'b0000, 4'b0000);
    wait_frame();
    check_frame(G0, G3, G0, G0, 4'b1111);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    check_frame(G0, G0, G0, G0, 4'b1111);
`endif

    // Reset during a lit digit clears everything.
    do_load(16'h7777, 4'b0000, 4'b0000);
    wait_frame();
    tick(1);
    rst_i = 1'b1;
    tick(1);
    check("midrst_an", 32'(an_o), 32'hF);
    check("midrst_seg", 32'(seg_o), 32'(GX));
    rst_i = 1'b0;
    tick(BC);
    check("midrst_relight_an", 32'(an_o), 32'hE);
    check("midrst_relight_seg", 32'(seg_o), 32'(G0));
    check("midrst_frame", 32'(frame_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
